// File: rtl/usb_link_ctrl_if.sv
// rtl/usb_link_ctrl_if.sv - link-layer signal bundle for usb_link_ctrl (optional toggle ports under USB_TOGGLE_EN)
interface usb_link_ctrl_if;
    logic       rx_pid_en;
    logic [3:0] rx_pid;
    logic [3:0] rx_endp;
    logic       crc5_err;
    logic       rx_data_done;
    logic       rx_data_crc_ok;
    logic       ep_ready;
    logic       ep_stall;
    logic       tx_data_done;
    logic       rx_handshake_on;
    logic       tx_data_start;
    logic       tx_hs_en;
    logic [3:0] tx_hs_pid;
    logic [3:0] cur_endp;
    logic       xfer_ok;
    logic       xfer_dir;
    logic       timeout;
`ifdef USB_TOGGLE_EN
    logic [3:0] rx_data_pid;
    logic [3:0] tx_data_pid;
`endif

    // Sequencer side
    modport slave (
        input  rx_pid_en, rx_pid, rx_endp, crc5_err, rx_data_done, rx_data_crc_ok,
        input  ep_ready, ep_stall, tx_data_done,
`ifdef USB_TOGGLE_EN
        input  rx_data_pid,
        output tx_data_pid,
`endif
        output rx_handshake_on, tx_data_start, tx_hs_en, tx_hs_pid, cur_endp,
        output xfer_ok, xfer_dir, timeout
    );

    // Link / endpoint side
    modport master (
        output rx_pid_en, rx_pid, rx_endp, crc5_err, rx_data_done, rx_data_crc_ok,
        output ep_ready, ep_stall, tx_data_done,
`ifdef USB_TOGGLE_EN
        output rx_data_pid,
        input  tx_data_pid,
`endif
        input  rx_handshake_on, tx_data_start, tx_hs_en, tx_hs_pid, cur_endp,
        input  xfer_ok, xfer_dir, timeout
    );
endinterface

// File: rtl/usb_link_ctrl.sv
// rtl/usb_link_ctrl.sv - device-side USB transaction sequencer; optional data toggle under USB_TOGGLE_EN
module usb_link_ctrl #(
    parameter int TIMEOUT = 800,
    parameter int TO_W    = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    usb_link_ctrl_if.slave    bus
);
    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
`ifdef USB_TOGGLE_EN
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
`endif
    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RX_DATA, TX_DATA, WAIT_HS} state_t;

    state_t          state, state_n;
    logic [TO_W-1:0] cnt, cnt_n;
    logic [3:0]      endp_q, endp_n;
    logic            is_setup, setup_n;
    logic            hs_en_q, hs_en_n;
    logic [3:0]      hs_pid_q, hs_pid_n;
    logic            start_q, start_n;
    logic            ok_q, ok_n;
    logic            dir_q, dir_n;
    logic            to_q, to_n;
    logic            tok_ok;
`ifdef USB_TOGGLE_EN
    logic [15:0]     toggle, tog_n;
`endif

    // A token counts only when its CRC5 is good and it is OUT, IN or SETUP
    assign tok_ok = bus.rx_pid_en && !bus.crc5_err &&
                    (bus.rx_pid == PID_OUT || bus.rx_pid == PID_IN || bus.rx_pid == PID_SETUP);

    // State, counter and registered output pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            endp_q   <= '0;
            is_setup <= 1'b0;
            hs_en_q  <= 1'b0;
            hs_pid_q <= '0;
            start_q  <= 1'b0;
            ok_q     <= 1'b0;
            dir_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            endp_q   <= endp_n;
            is_setup <= setup_n;
            hs_en_q  <= hs_en_n;
            hs_pid_q <= hs_pid_n;
            start_q  <= start_n;
            ok_q     <= ok_n;
            dir_q    <= dir_n;
            to_q     <= to_n;
        end
    end

`ifdef USB_TOGGLE_EN
    // Per-endpoint data toggle bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) toggle <= '0;
        else        toggle <= tog_n;
    end
`endif

    // Next-state and next-output decode; a fresh token preempts a pending transaction
    always_comb begin
        state_n  = state;
        cnt_n    = '0;
        endp_n   = endp_q;
        setup_n  = is_setup;
        hs_en_n  = 1'b0;
        hs_pid_n = 4'b0000;
        start_n  = 1'b0;
        ok_n     = 1'b0;
        dir_n    = 1'b0;
        to_n     = 1'b0;
`ifdef USB_TOGGLE_EN
        tog_n    = toggle;
`endif
        if (state == RX_DATA || state == WAIT_HS)
            cnt_n = cnt + TO_W'(1);

        if (tok_ok && state != TX_DATA) begin
            endp_n = bus.rx_endp;
            cnt_n  = '0;
            if (bus.rx_pid == PID_IN) begin
                state_n = IDLE;
                if (bus.ep_stall) begin
                    hs_en_n  = 1'b1;
                    hs_pid_n = PID_STALL;
                end else if (!bus.ep_ready) begin
                    hs_en_n  = 1'b1;
                    hs_pid_n = PID_NAK;
                end else begin
                    start_n = 1'b1;
                    state_n = TX_DATA;
                end
            end else begin
                state_n = RX_DATA;
                setup_n = (bus.rx_pid == PID_SETUP);
            end
        end else begin
            case (state)
                RX_DATA: begin
                    if (bus.rx_data_done) begin
                        state_n = IDLE;
                        if (bus.rx_data_crc_ok) begin
                            if (is_setup) begin
                                hs_en_n  = 1'b1;
                                hs_pid_n = PID_ACK;
                                ok_n     = 1'b1;
`ifdef USB_TOGGLE_EN
                                // SETUP always restarts the endpoint at DATA0
                                tog_n[endp_q] = 1'b0;
                                if (bus.rx_data_pid == PID_DATA0) tog_n[endp_q] = 1'b1;
                                else                              ok_n = 1'b0;
`endif
                            end else if (bus.ep_stall) begin
                                hs_en_n  = 1'b1;
                                hs_pid_n = PID_STALL;
                            end else if (!bus.ep_ready) begin
                                hs_en_n  = 1'b1;
                                hs_pid_n = PID_NAK;
                            end else begin
                                hs_en_n  = 1'b1;
                                hs_pid_n = PID_ACK;
                                ok_n     = 1'b1;
`ifdef USB_TOGGLE_EN
                                // A repeated packet is ACKed but not delivered again
                                if (bus.rx_data_pid == (toggle[endp_q] ? PID_DATA1 : PID_DATA0))
                                    tog_n[endp_q] = ~toggle[endp_q];
                                else
                                    ok_n = 1'b0;
`endif
                            end
                        end
                    end else if (cnt == CNT_LAST) begin
                        to_n    = 1'b1;
                        state_n = IDLE;
                    end
                end
                TX_DATA: begin
                    if (bus.tx_data_done) state_n = WAIT_HS;
                end
                WAIT_HS: begin
                    if (bus.rx_pid_en && !bus.crc5_err) begin
                        state_n = IDLE;
                        if (bus.rx_pid == PID_ACK) begin
                            ok_n  = 1'b1;
                            dir_n = 1'b1;
`ifdef USB_TOGGLE_EN
                            tog_n[endp_q] = ~toggle[endp_q];
`endif
                        end
                    end else if (cnt == CNT_LAST) begin
                        to_n    = 1'b1;
                        state_n = IDLE;
                    end
                end
                default: ;
            endcase
        end

        if (state_n == IDLE || state_n == TX_DATA)
            cnt_n = '0;
    end

    assign bus.rx_handshake_on = (state == WAIT_HS);
    assign bus.tx_data_start   = start_q;
    assign bus.tx_hs_en        = hs_en_q;
    assign bus.tx_hs_pid       = hs_pid_q;
    assign bus.cur_endp        = endp_q;
    assign bus.xfer_ok         = ok_q;
    assign bus.xfer_dir        = dir_q;
    assign bus.timeout         = to_q;
`ifdef USB_TOGGLE_EN
    assign bus.tx_data_pid     = (state == TX_DATA) ? (toggle[endp_q] ? PID_DATA1 : PID_DATA0) : 4'b0000;
`endif

endmodule

// File: tb/tb_usb_link_ctrl.sv
// tb/tb_usb_link_ctrl.sv - directed self-checking bench for usb_link_ctrl
module tb_usb_link_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    usb_link_ctrl_if bus ();

    usb_link_ctrl #(.TIMEOUT(800), .TO_W(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pid_pulse(input logic [3:0] pid, input logic [3:0] endp, input logic err);
        bus.rx_pid_en = 1'b1;
        bus.rx_pid    = pid;
        bus.rx_endp   = endp;
        bus.crc5_err  = err;
        step();
        bus.rx_pid_en = 1'b0;
        bus.crc5_err  = 1'b0;
    endtask

    task automatic data_pulse(input logic crc_ok);
        bus.rx_data_done   = 1'b1;
        bus.rx_data_crc_ok = crc_ok;
        step();
        bus.rx_data_done   = 1'b0;
    endtask

    task automatic txd_pulse();
        bus.tx_data_done = 1'b1;
        step();
        bus.tx_data_done = 1'b0;
    endtask

    initial begin
        int n;
        logic hs_seen;
        bus.rx_pid_en = 0; bus.rx_pid = 0; bus.rx_endp = 0; bus.crc5_err = 0;
        bus.rx_data_done = 0; bus.rx_data_crc_ok = 0;
        bus.ep_ready = 1; bus.ep_stall = 0; bus.tx_data_done = 0;
`ifdef USB_TOGGLE_EN
        bus.rx_data_pid = 4'b0011;
`endif
        step(); step();
        chk("rst_hs_on", bus.rx_handshake_on, 0);
        chk("rst_hs_en", bus.tx_hs_en, 0);
        chk("rst_start", bus.tx_data_start, 0);
        chk("rst_endp",  bus.cur_endp, 0);
        chk("rst_ok",    bus.xfer_ok, 0);
        chk("rst_to",    bus.timeout, 0);
        rst_n = 1'b1;
        step();

        // OUT ep3 with good data
        pid_pulse(4'b0001, 4'd3, 0);
        chk("out_endp", bus.cur_endp, 3);
        chk("out_no_hs", bus.tx_hs_en, 0);
        step(); step();
        data_pulse(1);
        chk("out_hs_en",  bus.tx_hs_en, 1);
        chk("out_hs_pid", bus.tx_hs_pid, 4'b0010);
        chk("out_ok",     bus.xfer_ok, 1);
        chk("out_dir",    bus.xfer_dir, 0);
        step();
        chk("out_hs_1cyc", bus.tx_hs_en, 0);
        chk("out_ok_1cyc", bus.xfer_ok, 0);

        // IN ep1 with data sent and host ACK
        pid_pulse(4'b1001, 4'd1, 0);
        chk("in_start", bus.tx_data_start, 1);
        chk("in_endp",  bus.cur_endp, 1);
        step();
        chk("in_start_1cyc", bus.tx_data_start, 0);
        chk("in_txdata_hs_off", bus.rx_handshake_on, 0);
        txd_pulse();
        chk("in_wait_hs_on", bus.rx_handshake_on, 1);
        step(); step();
        chk("in_wait_hs_hold", bus.rx_handshake_on, 1);
        pid_pulse(4'b0010, 4'd0, 0);
        chk("in_ok",  bus.xfer_ok, 1);
        chk("in_dir", bus.xfer_dir, 1);
        chk("in_hs_off", bus.rx_handshake_on, 0);

        // IN stalled, then IN not ready
        bus.ep_stall = 1;
        pid_pulse(4'b1001, 4'd2, 0);
        chk("stall_hs_en",  bus.tx_hs_en, 1);
        chk("stall_pid",    bus.tx_hs_pid, 4'b1110);
        chk("stall_nostart", bus.tx_data_start, 0);
        bus.ep_stall = 0; bus.ep_ready = 0;
        pid_pulse(4'b1001, 4'd2, 0);
        chk("nak_hs_en", bus.tx_hs_en, 1);
        chk("nak_pid",   bus.tx_hs_pid, 4'b1010);
        chk("nak_nostart", bus.tx_data_start, 0);
        bus.ep_ready = 1;

        // OUT with no data: timeout 800 cycles after entry
        pid_pulse(4'b0001, 4'd5, 0);
        n = 0; hs_seen = 0;
        while (n < 900) begin
            step();
            n++;
            if (bus.tx_hs_en) hs_seen = 1;
            if (bus.timeout) break;
        end
        chk("to_cycles", n, 800);
        chk("to_no_hs", hs_seen, 0);
        step();
        chk("to_1cyc", bus.timeout, 0);
        data_pulse(1);
        chk("to_idle_no_hs", bus.tx_hs_en, 0);

        // Completion in the timeout cycle wins
        pid_pulse(4'b0001, 4'd6, 0);
        for (int i = 0; i < 799; i++) step();
        data_pulse(1);
        chk("race_ack", bus.tx_hs_en, 1);
        chk("race_no_to", bus.timeout, 0);

        // Bad CRC5 token ignored
        pid_pulse(4'b0001, 4'd7, 1);
        chk("crc5_endp", bus.cur_endp, 6);
        data_pulse(1);
        chk("crc5_no_hs", bus.tx_hs_en, 0);

        // SETUP with bad CRC16: no handshake, back to idle
        pid_pulse(4'b1101, 4'd4, 0);
        data_pulse(0);
        chk("setup_bad_hs", bus.tx_hs_en, 0);
        chk("setup_bad_ok", bus.xfer_ok, 0);
        data_pulse(1);
        chk("setup_idle_hs", bus.tx_hs_en, 0);

        // SETUP ignores stall
        bus.ep_stall = 1;
        pid_pulse(4'b1101, 4'd4, 0);
        data_pulse(1);
        chk("setup_stall_pid", bus.tx_hs_pid, 4'b0010);
        chk("setup_stall_ok",  bus.xfer_ok, 1);
        bus.ep_stall = 0;

        // Token in RX_DATA aborts and starts IN
        pid_pulse(4'b0001, 4'd3, 0);
        pid_pulse(4'b1001, 4'd1, 0);
        chk("abort_start", bus.tx_data_start, 1);
        chk("abort_no_ok", bus.xfer_ok, 0);
        chk("abort_endp",  bus.cur_endp, 1);

        // Reset in WAIT_HS drops everything immediately
        txd_pulse();
        chk("pre_rst_hs_on", bus.rx_handshake_on, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_hs_on", bus.rx_handshake_on, 0);
        chk("rst_mid_endp",  bus.cur_endp, 0);
        step();
        rst_n = 1'b1;
        pid_pulse(4'b0010, 4'd0, 0);
        chk("rst_mid_no_ok", bus.xfer_ok, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
